// File: rtl/ahb_arbiter_pkg.sv
// ahb_arbiter_pkg: AHB transfer/burst encodings and arbiter state shared by the arbiter files
package ahb_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [2:0] {
        SINGLE = 3'd0,
        INCR   = 3'd1,
        WRAP4  = 3'd2,
        INCR4  = 3'd3,
        WRAP8  = 3'd4,
        INCR8  = 3'd5,
        WRAP16 = 3'd6,
        INCR16 = 3'd7
    } hburst_t;

    typedef enum logic [1:0] {
        PARK,
        OWN,
        BURST,
        LOCKED
    } arb_state_t;

    // Beats in a fixed-length burst; SINGLE and undefined-length INCR report 1.
    function automatic logic [4:0] burst_len(hburst_t b);
        return (b inside {WRAP4, INCR4})   ? 5'd4  :
               (b inside {WRAP8, INCR8})   ? 5'd8  :
               (b inside {WRAP16, INCR16}) ? 5'd16 : 5'd1;
    endfunction

endpackage

// File: rtl/ahb_arbiter_rr_picker.sv
// ahb_rr_picker: combinational round-robin picker, first requester after ptr wins
module ahb_rr_picker #(
    parameter  int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic [W-1:0] idx,
    output logic         any
);

    logic [W-1:0] c;

    // Walk the ring farthest-first so the nearest requester after ptr is assigned last and wins;
    // ptr itself is the farthest candidate, so it only wins when it is the sole requester.
    always_comb begin
        c   = '0;
        idx = '0;
        for (int k = N; k >= 1; k--) begin
            c = W'((int'(ptr) + k) % N);
            if (req[c]) idx = c;
        end
        any = |req;
        gnt = any ? N'(1) << idx : '0;
    end

endmodule

// File: rtl/ahb_arbiter.sv
// ahb_arbiter: round-robin AHB bus arbiter with burst/lock tenure, hold limit and bus parking
module ahb_arbiter
    import ahb_arbiter_pkg::*;
#(
    parameter  int NUM_MST  = 4,
    parameter  int DEF_MST  = 0,
    parameter  int MAX_HOLD = 16,
    localparam int MW       = $clog2(NUM_MST)
) (
    input  logic               h_clk,
    input  logic               h_reset,
    input  logic [NUM_MST-1:0] h_busreq_x,
    input  logic [NUM_MST-1:0] h_lock_x,
    input  logic [1:0]         h_trans,
    input  logic [2:0]         h_burst,
    input  logic               h_ready,
    output logic [NUM_MST-1:0] h_grant_x,
    output logic [MW-1:0]      h_master,
    output logic [MW-1:0]      h_master_d,
    output logic               h_mastlock
);

    localparam int            HW       = $clog2(MAX_HOLD);
    localparam logic [MW-1:0] DEF      = MW'(DEF_MST);
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD - 1);

    arb_state_t         state, state_nxt;
    logic [MW-1:0]      rr_ptr, pick_idx, win_idx;
    logic [NUM_MST-1:0] pick_gnt, win_gnt;
    logic [3:0]         beat_cnt;
    logic [HW-1:0]      hold_cnt;
    logic               any_req, own_req, own_lock, on_bus, idle_on_bus;
    logic               acc, nonseq_acc, seq_acc, fixed, rearb_ok, change;

    ahb_rr_picker #(.N(NUM_MST)) u_picker (
        .req (h_busreq_x),
        .ptr (rr_ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (any_req)
    );

    // Decode the address phase and decide re-arbitration; rr_ptr always names the granted master.
    // Transfers only count once the granted master actually drives the address bus (h_master caught up).
    always_comb begin
        own_req     = h_busreq_x[rr_ptr];
        own_lock    = h_lock_x[rr_ptr];
        on_bus      = h_master == rr_ptr;
        idle_on_bus = on_bus && h_trans == IDLE;
        acc         = h_ready && on_bus && h_trans[1];
        nonseq_acc  = acc && h_trans == NONSEQ;
        seq_acc     = acc && h_trans == SEQ;
        fixed       = burst_len(hburst_t'(h_burst)) > 5'd1;
        rearb_ok    = state == PARK  ? 1'b1 :
                      state == OWN   ? (!own_req || idle_on_bus || hold_cnt == HOLD_MAX) :
                      state == BURST ? ((seq_acc && beat_cnt == 4'd1) || idle_on_bus) : 1'b0;
        win_idx     = any_req ? pick_idx : DEF;
        win_gnt     = any_req ? pick_gnt : NUM_MST'(1) << DEF_MST;
        change      = h_ready && rearb_ok && win_idx != rr_ptr;
    end

    // Tenure state machine: park, plain ownership, fixed burst, locked sequence.
    always_comb begin
        state_nxt = state;
        if (h_ready)
            case (state)
                PARK:    state_nxt = any_req ? OWN : PARK;
                LOCKED:  state_nxt = (idle_on_bus && !own_lock) ? OWN : LOCKED;
                default: begin
                    if (rearb_ok && !any_req) state_nxt = PARK;
                    else if (change || (state == BURST && rearb_ok)) state_nxt = OWN;
                    else if (nonseq_acc) state_nxt = own_lock ? LOCKED : fixed ? BURST : OWN;
                end
            endcase
    end

    // State register.
    always_ff @(posedge h_clk) begin
        if (h_reset) state <= PARK;
        else state <= state_nxt;
    end

    // Grant, owner pipeline, lock flag and tenure counters; everything freezes while h_ready is low.
    always_ff @(posedge h_clk) begin
        if (h_reset) begin
            h_grant_x  <= NUM_MST'(1) << DEF_MST;
            rr_ptr     <= DEF;
            h_master   <= DEF;
            h_master_d <= DEF;
            h_mastlock <= 1'b0;
            beat_cnt   <= '0;
            hold_cnt   <= '0;
        end else if (h_ready) begin
            h_master   <= rr_ptr;
            h_master_d <= h_master;
            h_mastlock <= own_lock;
            if (change) begin
                h_grant_x <= win_gnt;
                rr_ptr    <= win_idx;
            end
            hold_cnt <= change ? '0 :
                        (acc && state == OWN && hold_cnt != HOLD_MAX) ? hold_cnt + 1'b1 : hold_cnt;
            beat_cnt <= (nonseq_acc && fixed) ? 4'(burst_len(hburst_t'(h_burst)) - 5'd1) :
                        (seq_acc && state == BURST && beat_cnt != 4'd0) ? beat_cnt - 1'b1 : beat_cnt;
        end
    end

endmodule

// File: tb/tb_ahb_arbiter.sv
// tb_ahb_arbiter: directed stimulus with a grant-change scoreboard for ahb_arbiter
module tb_ahb_arbiter;
    import ahb_arbiter_pkg::*;

    logic       h_clk, h_reset, h_ready, h_mastlock;
    logic [3:0] h_busreq_x, h_lock_x, h_grant_x;
    logic [1:0] h_trans, h_master, h_master_d;
    logic [2:0] h_burst;

    typedef struct {
        logic [3:0] gnt;
        int         beats;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   beats = 0;

    ahb_arbiter #(.NUM_MST(4), .DEF_MST(0), .MAX_HOLD(16)) dut (
        .h_clk      (h_clk),
        .h_reset    (h_reset),
        .h_busreq_x (h_busreq_x),
        .h_lock_x   (h_lock_x),
        .h_trans    (h_trans),
        .h_burst    (h_burst),
        .h_ready    (h_ready),
        .h_grant_x  (h_grant_x),
        .h_master   (h_master),
        .h_master_d (h_master_d),
        .h_mastlock (h_mastlock)
    );

    initial begin
        h_clk = 1'b0;
        forever #5 h_clk = ~h_clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input logic [3:0] g, input int b);
        exp_t e;
        e.gnt   = g;
        e.beats = b;
        sb.push_back(e);
    endtask

    // Apply inputs for the coming rising edge, then return at the following falling edge.
    task automatic drive(input logic [1:0] t, input logic [2:0] b, input logic r);
        h_trans = t;
        h_burst = b;
        h_ready = r;
        @(negedge h_clk);
    endtask

    task automatic do_reset();
        h_reset = 1'b1;
        drive(IDLE, SINGLE, 1'b1);
        drive(IDLE, SINGLE, 1'b1);
        h_reset = 1'b0;
    endtask

    task automatic wait_owner(input int m);
        bit ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            ok = h_master == 2'(m) && h_grant_x[m];
            if (!ok) drive(IDLE, SINGLE, 1'b1);
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL owner_wait: master=%0d grant=%b expected owner %0d", h_master, h_grant_x, m);
        end
    endtask

    // Monitor: counts accepted beats, pops the scoreboard on every grant change, checks the owner pipeline.
    initial begin
        logic [3:0] prev_g;
        logic [1:0] last_m, last_d;
        logic       rdy_q, rst_q;
        exp_t       e;
        forever begin
            @(posedge h_clk);
            rdy_q = h_ready;
            rst_q = h_reset;
            if (rst_q) beats = 0;
            else if (rdy_q && h_trans[1]) beats++;
            #1;
            if (rst_q) prev_g = h_grant_x;
            else begin
                if (h_grant_x != prev_g) begin
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL grant_unexpected: got %b with no change expected", h_grant_x);
                    end else begin
                        e = sb.pop_front();
                        chk("grant_value", 32'(h_grant_x), 32'(e.gnt));
                        chk("grant_beat", beats, e.beats);
                    end
                    prev_g = h_grant_x;
                end
                chk("master_d_pipe", 32'(h_master_d), 32'(rdy_q ? last_m : last_d));
            end
            last_m = h_master;
            last_d = h_master_d;
        end
    end

    initial begin
        int owners[4] = '{1, 2, 3, 1};
        int exp_d[4]  = '{0, 1, 2, 3};
        h_reset    = 1'b1;
        h_busreq_x = 4'b0000;
        h_lock_x   = 4'b0000;
        h_trans    = IDLE;
        h_burst    = SINGLE;
        h_ready    = 1'b1;

        // 1: reset and parking
        do_reset();
        chk("rst_grant", 32'(h_grant_x), 32'b0001);
        chk("rst_master", 32'(h_master), 0);
        chk("rst_master_d", 32'(h_master_d), 0);
        chk("rst_mastlock", 32'(h_mastlock), 0);
        repeat (3) drive(IDLE, SINGLE, 1'b1);
        chk("park_grant", 32'(h_grant_x), 32'b0001);
        chk("park_master", 32'(h_master), 0);

        // 2: round robin over M1..M3, one SINGLE each
        do_reset();
        push(4'b0010, 0); push(4'b0100, 1); push(4'b1000, 2); push(4'b0010, 3); push(4'b0001, 4);
        h_busreq_x = 4'b1110;
        for (int i = 0; i < 4; i++) begin
            wait_owner(owners[i]);
            chk("rr_master_d", 32'(h_master_d), exp_d[i]);
            drive(NONSEQ, SINGLE, 1'b1);
        end
        h_busreq_x = 4'b0000;
        repeat (3) drive(IDLE, SINGLE, 1'b1);
        chk("rr_sb_empty", sb.size(), 0);

        // 3: M2 INCR4 with wait states and BUSY while M1 requests
        do_reset();
        push(4'b0100, 0); push(4'b0010, 4); push(4'b0001, 4);
        h_busreq_x = 4'b0100;
        wait_owner(2);
        h_busreq_x = 4'b0110;
        drive(NONSEQ, INCR4, 1'b1);
        drive(SEQ, INCR4, 1'b0);
        drive(SEQ, INCR4, 1'b0);
        chk("burst_wait_grant", 32'(h_grant_x), 32'b0100);
        chk("burst_wait_master", 32'(h_master), 2);
        drive(SEQ, INCR4, 1'b1);
        drive(BUSY, INCR4, 1'b1);
        chk("burst_busy_grant", 32'(h_grant_x), 32'b0100);
        drive(SEQ, INCR4, 1'b1);
        chk("burst_beat3_grant", 32'(h_grant_x), 32'b0100);
        drive(SEQ, INCR4, 1'b1);
        chk("burst_end_grant", 32'(h_grant_x), 32'b0010);
        h_busreq_x = 4'b0000;
        repeat (3) drive(IDLE, SINGLE, 1'b1);
        chk("burst_sb_empty", sb.size(), 0);

        // 4: M3 locked INCR8 while everyone else requests
        do_reset();
        push(4'b1000, 0); push(4'b0001, 8);
        h_busreq_x = 4'b1000;
        h_lock_x   = 4'b1000;
        wait_owner(3);
        chk("lock_mastlock_on", 32'(h_mastlock), 1);
        h_busreq_x = 4'b1111;
        drive(NONSEQ, INCR8, 1'b1);
        repeat (7) drive(SEQ, INCR8, 1'b1);
        repeat (2) drive(IDLE, SINGLE, 1'b1);
        chk("lock_hold_grant", 32'(h_grant_x), 32'b1000);
        chk("lock_hold_mastlock", 32'(h_mastlock), 1);
        h_lock_x = 4'b0000;
        drive(IDLE, SINGLE, 1'b1);
        chk("lock_release_grant", 32'(h_grant_x), 32'b1000);
        chk("lock_mastlock_off", 32'(h_mastlock), 0);
        drive(IDLE, SINGLE, 1'b1);
        chk("lock_handover", 32'(h_grant_x), 32'b0001);
        h_busreq_x = 4'b0000;
        repeat (3) drive(IDLE, SINGLE, 1'b1);
        chk("lock_sb_empty", sb.size(), 0);

        // 5: M1 undefined-length INCR is cut at the hold limit
        do_reset();
        push(4'b0010, 0); push(4'b0100, 16); push(4'b0001, 16);
        h_busreq_x = 4'b0010;
        wait_owner(1);
        h_busreq_x = 4'b0110;
        drive(NONSEQ, INCR, 1'b1);
        repeat (14) drive(SEQ, INCR, 1'b1);
        chk("hold_15_grant", 32'(h_grant_x), 32'b0010);
        drive(SEQ, INCR, 1'b1);
        chk("hold_16_grant", 32'(h_grant_x), 32'b0100);
        h_busreq_x = 4'b0000;
        repeat (3) drive(IDLE, SINGLE, 1'b1);
        chk("hold_sb_empty", sb.size(), 0);

        // 6: reset lands on beat 5 of an M2 WRAP8
        do_reset();
        push(4'b0100, 0);
        h_busreq_x = 4'b0100;
        wait_owner(2);
        drive(NONSEQ, WRAP8, 1'b1);
        repeat (3) drive(SEQ, WRAP8, 1'b1);
        h_reset = 1'b1;
        drive(SEQ, WRAP8, 1'b1);
        h_reset = 1'b0;
        chk("midrst_grant", 32'(h_grant_x), 32'b0001);
        chk("midrst_master", 32'(h_master), 0);
        chk("midrst_master_d", 32'(h_master_d), 0);
        chk("midrst_mastlock", 32'(h_mastlock), 0);
        h_busreq_x = 4'b0000;
        repeat (3) drive(IDLE, SINGLE, 1'b1);
        chk("midrst_park_grant", 32'(h_grant_x), 32'b0001);
        chk("midrst_park_master", 32'(h_master), 0);
        chk("midrst_sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
